// File: rtl/sub_pkg.sv
// Shared types, widths and the term helper for the subtractor-stage accumulator.
package sub_pkg;

    localparam int DATA_W = 8;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    // Exact x-y as a sign-extended value: the borrow is the 9th (sign) bit
    // above the 8-bit upstream difference. Bits at and above acc_w are
    // zeroed; callers cast the result down to their accumulator width, so
    // accumulators wider than 32 bits are not supported.
    function automatic logic [31:0] term_ext(
        input logic [DATA_W-1:0] x,
        input logic [DATA_W-1:0] y,
        input logic [DATA_W-1:0] diff,
        input int                acc_w
    );
        logic        borrow;
        logic [31:0] t;
        borrow = (x < y);
        t = 32'($signed({borrow, diff}));
        for (int i = 0; i < 32; i++) begin
            if (i >= acc_w) begin
                t[i] = 1'b0;
            end
        end
        return t;
    endfunction

endpackage

// File: rtl/sub_term_check.sv
// Combinational per-sample decode: borrow, sign-extended exact difference,
// and a mismatch flag when the upstream diff is not (x-y) mod 256.
module sub_term_check
    import sub_pkg::*;
#(
    parameter int ACC_W = 16
) (
    input  logic [DATA_W-1:0] x_i,
    input  logic [DATA_W-1:0] y_i,
    input  logic [DATA_W-1:0] diff_i,
    output logic              borrow_o,
    output logic              mismatch_o,
    output logic [ACC_W-1:0]  term_o
);

    logic [DATA_W-1:0] expect_diff;

    assign borrow_o    = (x_i < y_i);
    assign expect_diff = x_i - y_i;
    assign mismatch_o  = (diff_i != expect_diff);
    // The term uses diff as given, so a faulty upstream value is still summed.
    assign term_o      = ACC_W'(term_ext(x_i, y_i, diff_i, ACC_W));

endmodule

// File: rtl/sub_block_accum.sv
// Block accumulator: sums NUM_SAMPLES exact differences, then holds the sum
// and borrow count until the downstream takes it.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; valid never depends on ready, and in_ready depends on state only.
module sub_block_accum
    import sub_pkg::*;
#(
    parameter int NUM_SAMPLES = 16,
    parameter int ACC_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] y,
    input  logic [DATA_W-1:0] diff,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic [8:0]        borrow_cnt,
    output logic              err,
    output state_e            state_o
);

    localparam int                CNT_W = (NUM_SAMPLES > 2) ? $clog2(NUM_SAMPLES) : 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(NUM_SAMPLES - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [8:0]         bc_q, bc_d;
    logic [ACC_W-1:0]   acc_out_q, acc_out_d;
    logic [8:0]         borrow_cnt_q, borrow_cnt_d;
    logic               err_q, err_d;

    logic               borrow;
    logic               mismatch;
    logic [ACC_W-1:0]   term;
    logic               accept;

    sub_term_check #(
        .ACC_W (ACC_W)
    ) u_term (
        .x_i        (x),
        .y_i        (y),
        .diff_i     (diff),
        .borrow_o   (borrow),
        .mismatch_o (mismatch),
        .term_o     (term)
    );

    assign accept = in_valid && (state_q == ACCUM);

    // Next-state and datapath update; every register defaults to holding.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        bc_d         = bc_q;
        acc_out_d    = acc_out_q;
        borrow_cnt_d = borrow_cnt_q;
        err_d        = err_q;
        case (state_q)
            ACCUM: begin
                if (accept) begin
                    err_d = err_q | mismatch;
                    if (cnt_q == '0) begin
                        // First sample of a block loads rather than adds.
                        acc_d = term;
                        bc_d  = 9'(borrow);
                        cnt_d = CNT_W'(1);
                    end else if (cnt_q == LAST) begin
                        acc_out_d    = acc_q + term;
                        borrow_cnt_d = bc_q + 9'(borrow);
                        cnt_d        = '0;
                        state_d      = HOLD;
                    end else begin
                        acc_d = acc_q + term;
                        bc_d  = bc_q + 9'(borrow);
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    // State and datapath registers; rst and clear flush everything.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_q      <= ACCUM;
            cnt_q        <= '0;
            acc_q        <= '0;
            bc_q         <= '0;
            acc_out_q    <= '0;
            borrow_cnt_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            bc_q         <= bc_d;
            acc_out_q    <= acc_out_d;
            borrow_cnt_q <= borrow_cnt_d;
            err_q        <= err_d;
        end
    end

    assign in_ready   = (state_q == ACCUM);
    assign out_valid  = (state_q == HOLD);
    assign acc_out    = acc_out_q;
    assign borrow_cnt = borrow_cnt_q;
    assign err        = err_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_sub_block_accum.sv
// Directed bench for sub_block_accum: a 4-sample instance for the functional
// cases and a 256-sample instance for the counter boundary.
module tb_sub_block_accum;
    import sub_pkg::*;

    localparam int ACC_W = 16;
    localparam int EXP_W = ACC_W + 9 + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT (4 samples) ----------------
    logic             clear4 = 1'b0;
    logic             in_valid4 = 1'b0;
    logic             in_ready4;
    logic [7:0]       x4 = '0, y4 = '0, d4 = '0;
    logic             out_valid4;
    logic             out_ready4 = 1'b0;
    logic [ACC_W-1:0] acc_out4;
    logic [8:0]       borrow_cnt4;
    logic             err4;
    state_e           st4;

    sub_block_accum #(.NUM_SAMPLES(4), .ACC_W(ACC_W)) dut4 (
        .clk(clk), .rst(rst), .clear(clear4),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .x(x4), .y(y4), .diff(d4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .acc_out(acc_out4), .borrow_cnt(borrow_cnt4), .err(err4),
        .state_o(st4)
    );

    // ---------------- DUT (256 samples) ----------------
    logic             clear256 = 1'b0;
    logic             in_valid256 = 1'b0;
    logic             in_ready256;
    logic [7:0]       x256 = '0, y256 = '0, d256 = '0;
    logic             out_valid256;
    logic             out_ready256 = 1'b1;
    logic [ACC_W-1:0] acc_out256;
    logic [8:0]       borrow_cnt256;
    logic             err256;
    state_e           st256;

    sub_block_accum #(.NUM_SAMPLES(256), .ACC_W(ACC_W)) dut256 (
        .clk(clk), .rst(rst), .clear(clear256),
        .in_valid(in_valid256), .in_ready(in_ready256),
        .x(x256), .y(y256), .diff(d256),
        .out_valid(out_valid256), .out_ready(out_ready256),
        .acc_out(acc_out256), .borrow_cnt(borrow_cnt256), .err(err256),
        .state_o(st256)
    );

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    int stalls   = 0;
    logic [EXP_W-1:0] exp_q[$];
    logic [EXP_W-1:0] exp256_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic push4(input logic [ACC_W-1:0] acc, input logic [8:0] bc, input logic e);
        exp_q.push_back({acc, bc, e});
    endtask

    // Monitor: compare each completed output handshake against the queue.
    always @(negedge clk) begin
        logic [EXP_W-1:0] e;
        if (!rst && !clear4 && out_valid4 && out_ready4) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL result4: unexpected output acc=0x%0h bc=%0d", acc_out4, borrow_cnt4);
            end else begin
                e = exp_q.pop_front();
                if ({acc_out4, borrow_cnt4, err4} !== e) begin
                    failures++;
                    $display("FAIL result4: got acc=0x%0h bc=%0d err=%0b expected acc=0x%0h bc=%0d err=%0b",
                             acc_out4, borrow_cnt4, err4, e[EXP_W-1 -: ACC_W], e[9:1], e[0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [EXP_W-1:0] e;
        if (!rst && !clear256 && out_valid256 && out_ready256) begin
            checks++;
            if (exp256_q.size() == 0) begin
                failures++;
                $display("FAIL result256: unexpected output acc=0x%0h bc=%0d", acc_out256, borrow_cnt256);
            end else begin
                e = exp256_q.pop_front();
                if ({acc_out256, borrow_cnt256, err256} !== e) begin
                    failures++;
                    $display("FAIL result256: got acc=0x%0h bc=%0d err=%0b expected acc=0x%0h bc=%0d err=%0b",
                             acc_out256, borrow_cnt256, err256, e[EXP_W-1 -: ACC_W], e[9:1], e[0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Present one sample to dut4 and return #1 after the edge that accepts it.
    // in_valid is left high so consecutive calls stream back-to-back.
    task automatic send4(input logic [7:0] xa, input logic [7:0] ya, input logic [7:0] da);
        int n;
        n = 0;
        in_valid4 = 1'b1; x4 = xa; y4 = ya; d4 = da;
        while (!in_ready4 && n < 50) begin
            stalls++;
            n++;
            @(posedge clk); #1;
        end
        if (n >= 50) begin
            checks++; failures++;
            $display("FAIL send4_timeout: in_ready stuck at %0b, required 1", in_ready4);
            in_valid4 = 1'b0;
        end else begin
            @(posedge clk); #1;
        end
    endtask

    task automatic idle4();
        in_valid4 = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        cycles(3);
        rst = 1'b0;

        // Reset state.
        chk("rst_in_ready", 32'(in_ready4), 32'd1);
        chk("rst_out_valid", 32'(out_valid4), 32'd0);
        chk("rst_acc_out", 32'(acc_out4), 32'd0);
        chk("rst_borrow_cnt", 32'(borrow_cnt4), 32'd0);
        chk("rst_err", 32'(err4), 32'd0);
        chk("rst_state", 32'(st4), 32'(ACCUM));

        // Mixed signs: 7 - 4 + 199 - 255 = -53, two borrows; hold 5 cycles.
        push4(16'hFFCB, 9'd2, 1'b0);
        send4(8'd10, 8'd3, 8'h07);
        send4(8'd5, 8'd9, 8'hFC);
        send4(8'd200, 8'd1, 8'hC7);
        send4(8'd0, 8'd255, 8'h01);
        chk("latency_out_valid", 32'(out_valid4), 32'd1);
        in_valid4 = 1'b1; x4 = 8'd50; y4 = 8'd1; d4 = 8'd0;
        for (int i = 0; i < 5; i++) begin
            chk("hold_in_ready", 32'(in_ready4), 32'd0);
            chk("hold_out_valid", 32'(out_valid4), 32'd1);
            chk("hold_acc_out", 32'(acc_out4), 32'h0000FFCB);
            chk("hold_borrow_cnt", 32'(borrow_cnt4), 32'd2);
            cycles(1);
        end
        idle4();
        out_ready4 = 1'b1;
        cycles(1);
        chk("release_in_ready", 32'(in_ready4), 32'd1);
        chk("release_out_valid", 32'(out_valid4), 32'd0);
        chk("release_acc_kept", 32'(acc_out4), 32'h0000FFCB);

        // Upstream fault: 7-2 given as 6, summed as +6; err is sticky.
        push4(16'd9, 9'd0, 1'b1);
        send4(8'd7, 8'd2, 8'h06);
        send4(8'd1, 8'd0, 8'h01);
        send4(8'd1, 8'd0, 8'h01);
        send4(8'd1, 8'd0, 8'h01);
        idle4();
        cycles(2);
        chk("err_set", 32'(err4), 32'd1);
        push4(16'd4, 9'd0, 1'b1);
        for (int i = 0; i < 4; i++) send4(8'd1, 8'd0, 8'h01);
        idle4();
        cycles(2);
        chk("err_sticky", 32'(err4), 32'd1);
        clear4 = 1'b1;
        cycles(1);
        clear4 = 1'b0;
        chk("clear_err", 32'(err4), 32'd0);
        chk("clear_acc_out", 32'(acc_out4), 32'd0);

        // Reset after a partial block: the partial sum must not leak.
        send4(8'd100, 8'd0, 8'd100);
        send4(8'd100, 8'd0, 8'd100);
        idle4();
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        push4(16'd4, 9'd0, 1'b0);
        for (int i = 0; i < 4; i++) send4(8'd1, 8'd0, 8'h01);
        idle4();
        cycles(2);

        // Streaming blocks: exactly one stall per block boundary.
        push4(16'hFC04, 9'd4, 1'b0);
        push4(16'hFC04, 9'd4, 1'b0);
        push4(16'hFC04, 9'd4, 1'b0);
        for (int i = 0; i < 4; i++) send4(8'd0, 8'd255, 8'h01);
        stalls = 0;
        for (int i = 0; i < 8; i++) send4(8'd0, 8'd255, 8'h01);
        idle4();
        chk("bubble_count", 32'(stalls), 32'd2);
        cycles(2);

        // Reset in HOLD drops the pending result.
        out_ready4 = 1'b0;
        for (int i = 0; i < 4; i++) send4(8'd3, 8'd1, 8'h02);
        idle4();
        chk("pre_rst_hold_valid", 32'(out_valid4), 32'd1);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        chk("rst_hold_out_valid", 32'(out_valid4), 32'd0);
        chk("rst_hold_acc_out", 32'(acc_out4), 32'd0);
        out_ready4 = 1'b1;

        // 256-sample block: 256 * 255 = 65280 = 0xFF00.
        exp256_q.push_back({16'hFF00, 9'd0, 1'b0});
        in_valid256 = 1'b1; x256 = 8'd255; y256 = 8'd0; d256 = 8'd255;
        for (int i = 0; i < 256; i++) begin
            n = 0;
            while (!in_ready256 && n < 50) begin n++; cycles(1); end
            if (n >= 50) begin
                checks++; failures++;
                $display("FAIL send256_timeout: in_ready=%0b required 1", in_ready256);
                break;
            end
            cycles(1);
        end
        in_valid256 = 1'b0;

        // Drain both scoreboards with a bounded wait.
        n = 0;
        while ((exp_q.size() != 0 || exp256_q.size() != 0) && n < 200) begin
            n++; cycles(1);
        end
        chk("leftover4", 32'(exp_q.size()), 32'd0);
        chk("leftover256", 32'(exp256_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
